// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, state enum and size helper for the load/store controller
// Purpose: memory width encodings (as driven on MemWidth), controller state
// encoding, and the width-to-byte-count helper used for split/fault decisions.
// Ports: none (package).
package lsu_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_SPLIT  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] width);
    return 4'd1 << width;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - sign/zero extension of 8/16/32/64-bit load data
// Purpose: combinational extension of the low 1/2/4/8 bytes of din to the full
// register width; shared with the writeback stage.
// Ports:
//   din          in  REG_WIDTH  raw data, low bytes meaningful
//   width        in  2          MEM_B/MEM_H/MEM_W/MEM_D
//   is_unsigned  in  1          1 = zero-extend, 0 = sign-extend
//   dout         out REG_WIDTH  extended data
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int REG_WIDTH = 64
) (
  input  logic [REG_WIDTH-1:0] din,
  input  logic [1:0]           width,
  input  logic                 is_unsigned,
  output logic [REG_WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    case (width)
      MEM_B:   dout = {{(REG_WIDTH-8){~is_unsigned & din[7]}}, din[7:0]};
      MEM_H:   dout = {{(REG_WIDTH-16){~is_unsigned & din[15]}}, din[15:0]};
      MEM_W:   dout = {{(REG_WIDTH-32){~is_unsigned & din[31]}}, din[31:0]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller between execute and data_mem
// Purpose: accepts one request at a time, issues a single aligned access or a
// sequence of byte accesses for misaligned requests, rejects out-of-range
// addresses without touching memory, and returns an extended load result.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_write, req_width,
//   req_unsigned, req_addr,
//   req_wdata                      request fields
//   resp_valid, resp_rdata,
//   resp_fault, resp_split         one-cycle completion
//   MemRead, MemWrite, MemSign,
//   MemWidth, full_addr, wdata     data_mem control/data
//   rdata                          data_mem combinational read data
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int REG_WIDTH  = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_width,
  input  logic                 req_unsigned,
  input  logic [REG_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [REG_WIDTH-1:0] resp_rdata,
  output logic                 resp_fault,
  output logic                 resp_split,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemSign,
  output logic [1:0]           MemWidth,
  output logic [REG_WIDTH-1:0] full_addr,
  output logic [REG_WIDTH-1:0] wdata,
  input  logic [REG_WIDTH-1:0] rdata
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] SINGLE = ST_SINGLE;
  localparam logic [1:0] SPLIT  = ST_SPLIT;
  localparam logic [1:0] RESP   = ST_RESP;

  logic [1:0]           state;
  logic                 lat_write;
  logic                 lat_unsigned;
  logic                 lat_fault;
  logic                 lat_split;
  logic [1:0]           lat_width;
  logic [REG_WIDTH-1:0] lat_addr;
  logic [REG_WIDTH-1:0] lat_wdata;
  logic [REG_WIDTH-1:0] acc;
  logic [2:0]           idx;

  logic [3:0]           req_size;
  logic [ADDR_WIDTH:0]  req_end;
  logic                 req_fault;
  logic                 req_aligned;
  logic                 last_byte;
  logic [7:0]           split_byte;
  logic [REG_WIDTH-1:0] acc_ext;

  assign req_size = size_bytes(req_width);
  // One extra bit on the last-byte address catches accesses running off the top.
  assign req_end     = {1'b0, req_addr[ADDR_WIDTH-1:0]} + (ADDR_WIDTH+1)'(req_size - 4'd1);
  assign req_fault   = (req_addr[REG_WIDTH-1:ADDR_WIDTH] != '0) || req_end[ADDR_WIDTH];
  assign req_aligned = (req_addr[2:0] & 3'(req_size - 4'd1)) == 3'd0;
  assign last_byte   = {1'b0, idx} == (size_bytes(lat_width) - 4'd1);
  assign split_byte  = lat_wdata[{idx, 3'b000} +: 8];

  lsu_extend #(.REG_WIDTH(REG_WIDTH)) u_extend (
    .din         (acc),
    .width       (lat_width),
    .is_unsigned (lat_unsigned),
    .dout        (acc_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_fault    <= 1'b0;
      lat_split    <= 1'b0;
      lat_width    <= MEM_B;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      acc          <= '0;
      idx          <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write    <= req_write;
            lat_unsigned <= req_unsigned;
            lat_width    <= req_width;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            lat_fault    <= req_fault;
            lat_split    <= !req_fault && !req_aligned;
            // Cleared here so stores and faults respond with zero data.
            acc          <= '0;
            idx          <= 3'd0;
            if (req_fault)        state <= RESP;
            else if (req_aligned) state <= SINGLE;
            else                  state <= SPLIT;
          end
        end
        SINGLE: begin
          if (!lat_write) acc <= rdata;
          state <= RESP;
        end
        SPLIT: begin
          if (!lat_write) acc[{idx, 3'b000} +: 8] <= rdata[7:0];
          idx <= idx + 3'd1;
          if (last_byte) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_rdata = resp_valid ? acc_ext : '0;
    resp_fault = resp_valid & lat_fault;
    resp_split = resp_valid & lat_split;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemSign    = 1'b0;
    MemWidth   = MEM_B;
    full_addr  = '0;
    wdata      = '0;
    case (state)
      SINGLE: begin
        MemRead   = !lat_write;
        MemWrite  = lat_write;
        MemWidth  = lat_width;
        MemSign   = lat_unsigned;
        full_addr = lat_addr;
        wdata     = lat_wdata;
      end
      SPLIT: begin
        // Raw bytes are fetched zero-extended; extension happens once at RESP.
        MemRead   = !lat_write;
        MemWrite  = lat_write;
        MemWidth  = MEM_B;
        MemSign   = 1'b1;
        full_addr = lat_addr + REG_WIDTH'(idx);
        wdata     = REG_WIDTH'(split_byte);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl against a request-level model
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_width = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic        resp_split;
  logic        MemRead, MemWrite, MemSign;
  logic [1:0]  MemWidth;
  logic [63:0] full_addr, wdata, rdata, mem_raw;

  always #5 clk = ~clk;

  lsu_ctrl #(.REG_WIDTH(64), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .resp_split(resp_split), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemSign(MemSign), .MemWidth(MemWidth),
    .full_addr(full_addr), .wdata(wdata), .rdata(rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] extend(input logic [63:0] v, input int n, input bit uns);
    logic [63:0] msk;
    if (n >= 8) return v;
    msk = (64'd1 << (8 * n)) - 64'd1;
    if (!uns && v[8 * n - 1]) return v | ~msk;
    return v & msk;
  endfunction

  // data_mem stand-in: combinational read, byte writes at the rising edge.
  logic [7:0] mem [0:1023];
  always_comb begin
    mem_raw = '0;
    for (int i = 0; i < 8; i++)
      if (i < (1 << MemWidth)) mem_raw[i*8 +: 8] = mem[(int'(full_addr[9:0]) + i) % 1024];
  end
  assign rdata = extend(mem_raw, 1 << MemWidth, MemSign);

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk);
      if (MemWrite)
        for (int i = 0; i < (1 << MemWidth); i++)
          mem[(int'(full_addr[9:0]) + i) % 1024] = 8'(wdata >> (8 * i));
    end
  end

  // Request-level model: one request in flight, k = access cycles before response.
  logic [7:0]  ref_mem [0:1023];
  bit          m_busy, m_w, m_uns, m_fault, m_split;
  logic [1:0]  m_width;
  logic [63:0] m_addr, m_wd, m_exp;
  int          m_d, m_k, m_n, m_edges, m_acc_edge, m_acc_cnt;

  initial begin
    logic [63:0] g;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    m_busy = 0; m_d = 0; m_k = 0; m_n = 1; m_edges = 0; m_acc_edge = 0; m_acc_cnt = 0;
    m_w = 0; m_uns = 0; m_fault = 0; m_split = 0; m_width = 0; m_addr = 0; m_wd = 0; m_exp = 0;
    forever begin
      @(posedge clk);
      m_edges++;
      if (!rst) begin
        m_busy = 0;
      end else if (m_busy) begin
        if (!m_fault && m_w && m_d < m_k) begin
          if (m_split) ref_mem[int'(m_addr[9:0]) + m_d] = 8'(m_wd >> (8 * m_d));
          else for (int i = 0; i < m_n; i++) ref_mem[int'(m_addr[9:0]) + i] = 8'(m_wd >> (8 * i));
        end
        if (m_d == m_k) m_busy = 0;
        else m_d++;
      end else if (req_valid) begin
        m_w = req_write; m_uns = req_unsigned; m_width = req_width;
        m_addr = req_addr; m_wd = req_wdata;
        m_n = 1 << req_width;
        m_fault = ((req_addr >> 10) != 0) || (int'(req_addr[9:0]) + m_n - 1 > 1023);
        m_split = !m_fault && ((req_addr % 64'(m_n)) != 0);
        m_k = m_fault ? 0 : (m_split ? m_n : 1);
        m_exp = '0;
        if (!m_fault && !m_w) begin
          g = '0;
          for (int i = 0; i < m_n; i++) g[i*8 +: 8] = ref_mem[int'(m_addr[9:0]) + i];
          m_exp = extend(g, m_n, m_uns);
        end
        m_d = 0;
        m_busy = 1;
        m_acc_edge = m_edges;
        m_acc_cnt++;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  logic        e_ready, e_rv, e_fault, e_split, e_rd, e_wr, e_sign, ck_wd;
  logic [1:0]  e_width;
  logic [63:0] e_rdata, e_addr, e_wdata, last_rdata;
  int          n_wr = 0, n_rd = 0, last_lat = 0;
  logic        last_fault = 0, last_split = 0;

  initial begin
    forever begin
      @(negedge clk);
      e_ready = 1; e_rv = 0; e_rdata = 0; e_fault = 0; e_split = 0;
      e_rd = 0; e_wr = 0; e_sign = 0; e_width = 0; e_addr = 0; e_wdata = 0; ck_wd = 1;
      if (rst && m_busy) begin
        e_ready = 0;
        if (m_d == 0) begin
          n_wr = 0; n_rd = 0; last_lat = 0; last_rdata = '1; last_fault = 0; last_split = 0;
        end
        if (m_d == m_k) begin
          e_rv = 1; e_rdata = m_exp; e_fault = m_fault; e_split = m_split;
        end else begin
          e_rd = !m_w; e_wr = m_w; ck_wd = m_w;
          if (m_split) begin
            e_sign = 1; e_addr = m_addr + 64'(m_d); e_wdata = 64'(8'(m_wd >> (8 * m_d)));
          end else begin
            e_width = m_width; e_sign = m_uns; e_addr = m_addr; e_wdata = m_wd;
          end
        end
      end
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("resp_valid", 64'(resp_valid), 64'(e_rv));
      chk("resp_rdata", resp_rdata, e_rdata);
      chk("resp_fault", 64'(resp_fault), 64'(e_fault));
      chk("resp_split", 64'(resp_split), 64'(e_split));
      chk("MemRead", 64'(MemRead), 64'(e_rd));
      chk("MemWrite", 64'(MemWrite), 64'(e_wr));
      chk("MemWidth", 64'(MemWidth), 64'(e_width));
      chk("MemSign", 64'(MemSign), 64'(e_sign));
      chk("full_addr", full_addr, e_addr);
      if (ck_wd) chk("wdata", wdata, e_wdata);
      n_wr += int'(MemWrite);
      n_rd += int'(MemRead);
      if (resp_valid) begin
        last_rdata = resp_rdata; last_fault = resp_fault; last_split = resp_split;
        last_lat = m_edges - m_acc_edge + 1;
      end
    end
  end

  task automatic issue(input bit w, input logic [1:0] wd, input bit u,
                       input logic [63:0] a, input logic [63:0] dat, input bit hold);
    int c0;
    c0 = m_acc_cnt;
    req_valid = 1; req_write = w; req_width = wd; req_unsigned = u;
    req_addr = a; req_wdata = dat;
    for (int i = 0; i < 40 && m_acc_cnt == c0; i++) begin
      @(posedge clk); #1;
    end
    chk("accept_timeout", 64'(m_acc_cnt == c0), 64'd0);
    if (!hold) req_valid = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && m_busy; i++) begin
      @(posedge clk); #1;
    end
    chk("done_timeout", 64'(m_busy), 64'd0);
  endtask

  int a1, a2;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    #1 rst = 1;

    // 1: aligned double store then load
    issue(1, 2'd3, 0, 64'h8, 64'h1122334455667788, 0); wait_done();
    chk("t1_sd_writes", 64'(n_wr), 64'd1);
    chk("t1_sd_lat", 64'(last_lat), 64'd2);
    issue(0, 2'd3, 0, 64'h8, 64'h0, 0); wait_done();
    chk("t1_ld_rdata", last_rdata, 64'h1122334455667788);
    chk("t1_ld_lat", 64'(last_lat), 64'd2);

    // 2: misaligned word store/loads
    issue(1, 2'd2, 0, 64'h21, 64'h89ABCDEF, 0); wait_done();
    chk("t2_sw_writes", 64'(n_wr), 64'd4);
    chk("t2_sw_split", 64'(last_split), 64'd1);
    chk("t2_mem21", 64'(mem[33]), 64'hEF);
    chk("t2_mem22", 64'(mem[34]), 64'hCD);
    chk("t2_mem23", 64'(mem[35]), 64'hAB);
    chk("t2_mem24", 64'(mem[36]), 64'h89);
    issue(0, 2'd2, 0, 64'h21, 64'h0, 0); wait_done();
    chk("t2_lw_rdata", last_rdata, 64'hFFFFFFFF89ABCDEF);
    chk("t2_lw_lat", 64'(last_lat), 64'd5);
    issue(0, 2'd2, 1, 64'h21, 64'h0, 0); wait_done();
    chk("t2_lwu_rdata", last_rdata, 64'h0000000089ABCDEF);

    // 3: half and byte, signed and unsigned
    issue(1, 2'd1, 0, 64'h40, 64'hCDEF, 0); wait_done();
    issue(0, 2'd1, 0, 64'h40, 64'h0, 0); wait_done();
    chk("t3_lh_rdata", last_rdata, 64'hFFFFFFFFFFFFCDEF);
    issue(1, 2'd0, 0, 64'h60, 64'h12345678000000AA, 0); wait_done();
    issue(0, 2'd0, 1, 64'h60, 64'h0, 0); wait_done();
    chk("t3_lbu_rdata", last_rdata, 64'hAA);
    issue(0, 2'd0, 0, 64'h60, 64'h0, 0); wait_done();
    chk("t3_lb_rdata", last_rdata, 64'hFFFFFFFFFFFFFFAA);

    // 4: faults
    issue(0, 2'd3, 0, 64'h3FC, 64'h0, 0); wait_done();
    chk("t4_ld_fault", 64'(last_fault), 64'd1);
    chk("t4_ld_rdata", last_rdata, 64'h0);
    chk("t4_ld_lat", 64'(last_lat), 64'd1);
    chk("t4_ld_reads", 64'(n_rd), 64'd0);
    issue(0, 2'd0, 0, 64'h400, 64'h0, 0); wait_done();
    chk("t4_lb_fault", 64'(last_fault), 64'd1);
    chk("t4_lb_lat", 64'(last_lat), 64'd1);
    chk("t4_lb_reads", 64'(n_rd), 64'd0);

    // 5: reset in the middle of a split store
    issue(1, 2'd3, 0, 64'h3, 64'h0807060504030201, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("t5_ready", 64'(req_ready), 64'd1);
    chk("t5_mem03", 64'(mem[3]), 64'h01);
    chk("t5_mem04", 64'(mem[4]), 64'h02);
    chk("t5_mem05", 64'(mem[5]), 64'h03);
    chk("t5_mem06", 64'(mem[6]), 64'h5C);
    chk("t5_mem07", 64'(mem[7]), 64'h5D);
    chk("t5_mem08", 64'(mem[8]), 64'h88);
    chk("t5_mem0A", 64'(mem[10]), 64'h66);
    #1;

    // 6: request held valid across a split load
    issue(0, 2'd2, 0, 64'h21, 64'h0, 1);
    a1 = m_acc_edge;
    issue(0, 2'd3, 0, 64'h8, 64'h0, 0);
    a2 = m_acc_edge;
    chk("t6_accept_gap", 64'(a2 - a1), 64'd6);
    wait_done();
    chk("t6_ld_rdata", last_rdata, 64'h1122334455667788);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
